// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; frames are sent back-to-back while
// the FIFO holds data, each symbol lasting CLOCK_FREQ/BAUD_RATE clock cycles.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYM   = CLOCK_FREQ / BAUD_RATE;
    localparam int SYM_W = (SYM > 1) ? $clog2(SYM) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [7:0]       shift;
    logic [SYM_W-1:0] sym_cnt;
    logic [2:0]       bit_idx;
    logic             push;
    logic             pop;
    logic             sym_last;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens a slot for a push into a full FIFO.
    assign data_in_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push          = data_in_valid && data_in_ready;
    assign sym_last      = (sym_cnt == SYM_W'(SYM - 1));
    assign pop           = (fifo_count != '0) &&
                           ((state == IDLE) || ((state == STOP) && sym_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            sym_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift      <= mem[rd_ptr];
                        state      <= START;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        sym_cnt    <= '0;
                    end
                end
                START: begin
                    if (sym_last) begin
                        sym_cnt    <= '0;
                        bit_idx    <= '0;
                        state      <= DATA;
                        serial_out <= shift[0];
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sym_last) begin
                        sym_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state      <= STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (sym_last) begin
                        sym_cnt <= '0;
                        // Chain straight into the next start bit when data waits.
                        if (pop) begin
                            shift      <= mem[rd_ptr];
                            state      <= START;
                            serial_out <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: time-based frame model checked every cycle, a line
// decoder, directed boundary scenarios and a randomized traffic phase.
module tb_uart_tx_fifo;

    localparam int CF    = 50_000_000;
    localparam int BR    = 10_000_000;
    localparam int SYM   = CF / BR;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * SYM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_epoch = 0;

    logic [7:0] q[$];
    logic [7:0] acc_log[$];
    logic [7:0] decoded[$];
    int         dec_start[$];

    // Model: a frame is just "byte + cycles elapsed since its start bit began".
    bit         m_in_frame = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_r;
    logic       m_v;
    logic [7:0] m_d;
    logic [7:0] m_pb;
    int         m_cnt;
    bit         m_popped;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_level();
        int s;
        s = m_t / SYM;
        if (s == 0) return 0;
        else if (s <= 8) return int'(m_byte[s-1]);
        else return 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_r = rst;
            m_v = data_in_valid;
            m_d = data_in;
            if (!m_r) begin
                q.delete();
                m_in_frame = 1'b0;
                m_t = 0;
            end else begin
                m_cnt = q.size();
                m_popped = 1'b0;
                if (m_cnt > 0 && (!m_in_frame || m_t == FRAME - 1)) begin
                    m_pb = q.pop_front();
                    m_popped = 1'b1;
                end
                if (m_v && m_cnt < DEPTH) begin
                    q.push_back(m_d);
                    acc_log.push_back(m_d);
                end
                if (m_in_frame) begin
                    if (m_t == FRAME - 1) begin
                        if (m_popped) begin
                            m_t = 0;
                            m_byte = m_pb;
                        end else begin
                            m_in_frame = 1'b0;
                        end
                    end else begin
                        m_t++;
                    end
                end else if (m_popped) begin
                    m_in_frame = 1'b1;
                    m_t = 0;
                    m_byte = m_pb;
                end
            end
            #1;
            check("serial_out", int'(serial_out), m_in_frame ? m_level() : 1);
            check("busy", int'(busy), int'(m_in_frame));
            check("fifo_count", int'(fifo_count), q.size());
            check("data_in_ready", int'(data_in_ready), int'(q.size() < DEPTH));
        end
    end

    // Line decoder: samples mid-symbol, resynchronising on each start bit.
    int         d_ep;
    int         d_st;
    logic [7:0] d_b;
    logic       d_sb;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst && serial_out === 1'b0) begin
                d_ep = rst_epoch;
                d_st = cyc;
                d_b  = 8'h00;
                repeat (SYM / 2) begin @(posedge clk); #1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (SYM) begin @(posedge clk); #1; end
                    d_b[i] = serial_out;
                end
                repeat (SYM) begin @(posedge clk); #1; end
                d_sb = serial_out;
                if (d_ep == rst_epoch && rst) begin
                    check("stop_bit", int'(d_sb), 1);
                    decoded.push_back(d_b);
                    dec_start.push_back(d_st);
                end
                repeat (SYM - 1 - SYM / 2) begin @(posedge clk); #1; end
            end
        end
    end

    task automatic clear_logs();
        decoded.delete();
        dec_start.delete();
        acc_log.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
    task automatic offer(input logic [7:0] b, input bit junk);
        int w;
        w = 0;
        data_in_valid = 1'b1;
        while (!data_in_ready && w < 200) begin
            data_in = junk ? 8'($urandom) : b;
            @(negedge clk);
            w++;
        end
        data_in = b;
        check("accept_wait", int'(w < 200), 1);
        @(negedge clk);
    endtask

    task automatic drain_and_compare(input string tag);
        int w;
        w = 0;
        while (w < 1500 && !(!busy && fifo_count == 0 && decoded.size() == acc_log.size())) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, int'(w < 1500), 1);
        check({tag, "_nbytes"}, decoded.size(), acc_log.size());
        for (int i = 0; i < decoded.size() && i < acc_log.size(); i++) begin
            check({tag, "_byte"}, int'(decoded[i]), int'(acc_log[i]));
        end
    endtask

    logic       ser [60];
    logic       bz [60];
    logic       exp_bits [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] burst [9] = '{8'h0d, 8'h0a, 8'h31, 8'h35, 8'h31, 8'h3e, 8'h20, 8'h78, 8'h79};
    logic [7:0] simul [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h5a};

    initial begin
        int nb;
        int highs;
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_serial", int'(serial_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ready", int'(data_in_ready), 1);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_serial", int'(serial_out), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_count", int'(fifo_count), 0);
        check("idle_ready", int'(data_in_ready), 1);

        // Single byte 0x78
        clear_logs();
        data_in = 8'h78;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            ser[k] = serial_out;
            bz[k]  = busy;
            @(negedge clk);
        end
        nb = 0;
        for (int k = 0; k < 60; k++) nb += int'(bz[k]);
        check("single_busy_cycles", nb, 50);
        check("single_busy_pre", int'(bz[0]), 0);
        check("single_busy_first", int'(bz[1]), 1);
        check("single_busy_last", int'(bz[50]), 1);
        check("single_busy_after", int'(bz[51]), 0);
        check("single_line_pre", int'(ser[0]), 1);
        check("single_start_first", int'(ser[1]), 0);
        check("single_start_last", int'(ser[5]), 0);
        for (int i = 0; i < 8; i++) begin
            check("single_bit_first", int'(ser[6 + 5 * i]), int'(exp_bits[i]));
            check("single_bit_last", int'(ser[10 + 5 * i]), int'(exp_bits[i]));
        end
        check("single_stop_first", int'(ser[46]), 1);
        check("single_stop_last", int'(ser[50]), 1);
        check("single_idle_after", int'(ser[51]), 1);
        drain_and_compare("single");
        check("single_decoded_n", decoded.size(), 1);
        if (decoded.size() == 1) check("single_decoded", int'(decoded[0]), 'h78);

        // Burst to full, then backpressure with changing data
        clear_logs();
        for (int i = 0; i < 9; i++) offer(burst[i], 1'b0);
        check("burst_ready_low", int'(data_in_ready), 0);
        check("burst_full_count", int'(fifo_count), 8);
        check("burst_accepted", acc_log.size(), 9);
        offer(8'ha5, 1'b1);
        data_in_valid = 1'b0;
        drain_and_compare("burst");
        check("burst_decoded_n", decoded.size(), 10);
        if (decoded.size() == 10) begin
            for (int i = 0; i < 9; i++) check("burst_decoded", int'(decoded[i]), int'(burst[i]));
            check("backpressure_next", int'(decoded[9]), 'ha5);
            for (int i = 0; i < 9; i++) check("burst_gap", dec_start[i+1] - dec_start[i], FRAME);
        end

        // Reset during DATA bit 3 with 4 bytes queued
        clear_logs();
        offer(8'hf0, 1'b0);
        offer(8'h11, 1'b0);
        offer(8'h22, 1'b0);
        offer(8'h33, 1'b0);
        offer(8'h44, 1'b0);
        data_in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("midrst_busy_before", int'(busy), 1);
        check("midrst_count_before", int'(fifo_count), 4);
        check("midrst_bit3_before", int'(serial_out), 0);
        rst_epoch++;
        rst = 1'b0;
        #1;
        check("midrst_serial", int'(serial_out), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(fifo_count), 0);
        check("midrst_ready", int'(data_in_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        highs = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            highs += int'(serial_out);
        end
        check("midrst_line_idle", highs, 120);
        check("midrst_count_after", int'(fifo_count), 0);
        check("midrst_no_frames", decoded.size(), 0);

        // Push in the last STOP cycle while three bytes are queued
        clear_logs();
        for (int i = 0; i < 4; i++) offer(simul[i], 1'b0);
        data_in_valid = 1'b0;
        repeat (47) @(negedge clk);
        check("simul_count_before", int'(fifo_count), 3);
        check("simul_stop_level", int'(serial_out), 1);
        data_in = simul[4];
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        check("simul_count_after", int'(fifo_count), 3);
        check("simul_next_start", int'(serial_out), 0);
        check("simul_busy", int'(busy), 1);
        drain_and_compare("simul");
        check("simul_decoded_n", decoded.size(), 5);
        if (decoded.size() == 5) begin
            for (int i = 0; i < 5; i++) check("simul_decoded", int'(decoded[i]), int'(simul[i]));
            for (int i = 0; i < 4; i++) check("simul_gap", dec_start[i+1] - dec_start[i], FRAME);
        end

        // Randomized traffic: dense phase saturates the FIFO, sparse phase lets it idle
        clear_logs();
        for (int k = 0; k < 250; k++) begin
            data_in_valid = ($urandom_range(0, 1) == 0);
            data_in = 8'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k < 1500; k++) begin
            data_in_valid = ($urandom_range(0, 29) == 0);
            data_in = 8'($urandom);
            @(negedge clk);
        end
        data_in_valid = 1'b0;
        drain_and_compare("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, the serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the number of FIFO entries; it is a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port data_in, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port data_in_valid, input, 1 bit: producer offers data_in.
REQ-008 SHALL have port data_in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-009 SHALL have port serial_out, output, 1 bit: 8N1 line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-012 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer division); each line symbol is held exactly SYMBOL_EDGE_TIME cycles.
REQ-013 SHALL enqueue data_in on a rising clk edge where data_in_valid && data_in_ready.
REQ-014 SHALL drive data_in_ready = (fifo_count < FIFO_DEPTH), combinational from registered count only.
REQ-015 SHALL, when full, refuse a push even if a pop happens in the same cycle.
REQ-016 SHALL, on a simultaneous push and pop, leave fifo_count unchanged, and SHALL wrap both pointers modulo FIFO_DEPTH.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL, in IDLE with fifo_count != 0, pop the head byte into the shift register and enter START on the next edge.
REQ-019 SHALL, in START, drive serial_out=0 for SYMBOL_EDGE_TIME cycles, then enter DATA.
REQ-020 SHALL, in DATA, send 8 bits LSB first, each for SYMBOL_EDGE_TIME cycles, using a 3-bit bit index; after bit 7 it enters STOP.
REQ-021 SHALL, in STOP, drive serial_out=1 for SYMBOL_EDGE_TIME cycles.
REQ-022 SHALL, in the last STOP cycle, pop and go directly to START if the FIFO is non-empty, otherwise go to IDLE; back-to-back frames therefore have zero idle cycles.
REQ-023 SHALL make every frame exactly 10*SYMBOL_EDGE_TIME cycles long.
REQ-024 SHALL drive serial_out from a register (glitch-free), 1 in IDLE.
REQ-025 SHALL drive busy = 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 SHALL never drop, duplicate or reorder an accepted byte.

Reset
REQ-027 SHALL, while rst=0, asynchronously force: state IDLE, serial_out=1, busy=0, fifo_count=0, pointers 0, symbol counter 0, bit index 0.
REQ-028 SHALL, on reset asserted mid-frame, abandon the frame immediately and discard FIFO contents; no partial frame resumes after release.
REQ-029 SHALL drive data_in_ready=1 during and immediately after reset; the first transmission begins only after a post-reset push.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000, SYMBOL_EDGE_TIME=5, FIFO_DEPTH=8)
REQ-030 SHALL be verified for reset: rst=0 for 10 cycles -> serial_out=1, busy=0, fifo_count=0, data_in_ready=1, held while idle.
REQ-031 SHALL be verified for a single byte: push 0x78 -> one cycle later serial_out=0 for 5 cycles, then bits 0,0,0,1,1,1,1,0 at 5 cycles each, then stop 1 for 5 cycles; busy=1 for exactly 50 cycles.
REQ-032 SHALL be verified for the burst/full boundary: data_in_valid held high with 0x0d,0x0a,0x31,0x35,0x31,0x3e,0x20,0x78,0x79 -> exactly 9 bytes accepted before data_in_ready=0; the bench decodes the same 9 bytes in order, contiguous over 450 cycles, with no idle high between frames.
REQ-033 SHALL be verified for backpressure: data_in_valid=1 with data_in_ready=0 and data_in changing -> no byte accepted; the next decoded byte is the first byte offered after data_in_ready returns to 1.
REQ-034 SHALL be verified for reset mid-frame: rst=0 during DATA bit 3 with 4 bytes queued -> serial_out=1 in the same cycle, and after release the line stays idle with fifo_count=0.
REQ-035 SHALL be verified for simultaneous push and pop: push in the last STOP cycle with fifo_count=3 -> fifo_count stays 3 and the next frame starts with no gap.
